// File: rtl/pending_encoder8_3_pkg.sv
// Shared constants, state encoding and helpers for the pending 8-to-3 request encoder.
// Imported by the interface, the priority encoder and the top level.
package pending_encoder8_3_pkg;

   // Elaboration-time ceil(log2(v)); returns 0 for v <= 1.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int N = 8;
   localparam int W = clog2_f(N);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/pending_encoder8_3_if.sv
// Request/handshake bundle of the pending encoder.
// master drives en/req/ready and observes the rest; slave is the encoder side.
interface pending_encoder8_3_if;
   import pending_encoder8_3_pkg::*;

   // valid/ready: a code transfers on every rising edge where valid and ready are
   // both 1; while valid=1 and ready=0 the code stays stable; valid never waits on ready.
   logic         en;
   logic [N-1:0] req;
   logic         ready;
   logic         valid;
   logic [W-1:0] code;
   logic [N-1:0] pending;
   logic         ovf;

   modport master (output en, req, ready, input valid, code, pending, ovf);
   modport slave  (input en, req, ready, output valid, code, pending, ovf);
endinterface

// File: rtl/pending_encoder8_3_prio_enc8_3.sv
// Combinational highest-index-wins priority encoder; outputs 0 for all-zero input.
// Reusable wherever a one-of-N index of the top set bit is needed.
module prio_enc8_3
   import pending_encoder8_3_pkg::*;
(
   input  logic [N-1:0] in,
   output logic [W-1:0] out,
   output logic         any_o
);

   always_comb begin
      out   = '0;
      any_o = |in;
      // Ascending scan: the last set bit seen is the highest index.
      for (int i = 0; i < N; i++) begin
         if (in[i]) out = W'(i);
      end
   end

endmodule

// File: rtl/pending_encoder8_3.sv
// Sticky request capture plus one-code-per-handshake index output.
// Holds the pending register, the IDLE/HOLD FSM, registered outputs and ovf.
module pending_encoder8_3
   import pending_encoder8_3_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   pending_encoder8_3_if.slave  bus,
   output state_t               state
);

   logic [N-1:0] pending_q;
   logic [W-1:0] code_q;
   logic         valid_q;
   logic         ovf_q;
   logic [W-1:0] enc_code;
   logic         enc_any;
   logic         load;
   logic [N-1:0] clear_mask;

   prio_enc8_3 u_prio (
      .in    (pending_q),
      .out   (enc_code),
      .any_o (enc_any)
   );

   // The encoder sees only registered pending, so same-cycle req never feeds code.
   always_comb begin
      load       = bus.en && enc_any && ((state == IDLE) || bus.ready);
      clear_mask = '0;
      if (load) clear_mask = {{(N-1){1'b0}}, 1'b1} << enc_code;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         ovf_q <= bus.en && |(bus.req & pending_q & ~clear_mask);
         // Set wins over clear: a req on the line being loaded re-arms it.
         if (bus.en) pending_q <= (pending_q & ~clear_mask) | bus.req;
         case (state)
            IDLE: begin
               if (load) begin
                  code_q  <= enc_code;
                  valid_q <= 1'b1;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (bus.ready) begin
                  if (load) begin
                     code_q <= enc_code;
                  end else begin
                     valid_q <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.valid   = valid_q;
   assign bus.code    = code_q;
   assign bus.pending = pending_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Directed bench for pending_encoder8_3: a per-cycle vector table run from reset,
// followed by a hand-written reset-in-HOLD sequence.
module tb_pending_encoder8_3;
   import pending_encoder8_3_pkg::*;

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic       ready;
      logic       exp_valid;
      logic [2:0] exp_code;
      logic [7:0] exp_pending;
      logic       exp_ovf;
   } vec_t;

   logic   clk;
   logic   rst_n;
   state_t state;
   int     n_checks;
   int     n_fail;
   vec_t   vq[$];

   pending_encoder8_3_if bus ();

   pending_encoder8_3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .state (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] req, input logic ready);
      bus.en    = en;
      bus.req   = req;
      bus.ready = ready;
   endtask

   // Apply inputs, take one edge, sample 1 time unit later.
   task automatic step(input logic en, input logic [7:0] req, input logic ready);
      drive(en, req, ready);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic en, input logic [7:0] req, input logic ready,
                      input logic ev, input logic [2:0] ec, input logic [7:0] ep,
                      input logic eo);
      vec_t v;
      v.en = en; v.req = req; v.ready = ready;
      v.exp_valid = ev; v.exp_code = ec; v.exp_pending = ep; v.exp_ovf = eo;
      vq.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input vec_t v);
      chk({tag, " valid"}, 32'(bus.valid), 32'(v.exp_valid));
      chk({tag, " pending"}, 32'(bus.pending), 32'(v.exp_pending));
      chk({tag, " ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
      chk({tag, " state"}, 32'(state), 32'(v.exp_valid));
      if (v.exp_valid) chk({tag, " code"}, 32'(bus.code), 32'(v.exp_code));
   endtask

   initial begin
      vec_t v;
      n_checks = 0;
      n_fail   = 0;

      // en req ready | valid code pending ovf  (outputs after the edge)
      // single request
      add(1, 8'h04, 1,  0, 0, 8'h04, 0);
      add(1, 8'h00, 1,  1, 2, 8'h00, 0);
      add(1, 8'h00, 1,  0, 0, 8'h00, 0);
      // multi-hot 1010_0001 -> 7, 5, 0
      add(1, 8'hA1, 1,  0, 0, 8'hA1, 0);
      add(1, 8'h00, 1,  1, 7, 8'h21, 0);
      add(1, 8'h00, 1,  1, 5, 8'h01, 0);
      add(1, 8'h00, 1,  1, 0, 8'h00, 0);
      add(1, 8'h00, 1,  0, 0, 8'h00, 0);
      // backpressure 0001_0010 -> 4 held, then 1
      add(1, 8'h12, 0,  0, 0, 8'h12, 0);
      add(1, 8'h00, 0,  1, 4, 8'h02, 0);
      add(1, 8'h00, 0,  1, 4, 8'h02, 0);
      add(1, 8'h00, 0,  1, 4, 8'h02, 0);
      add(1, 8'h00, 0,  1, 4, 8'h02, 0);
      add(1, 8'h00, 0,  1, 4, 8'h02, 0);
      add(1, 8'h00, 1,  1, 1, 8'h00, 0);
      add(1, 8'h00, 1,  0, 0, 8'h00, 0);
      // overflow on second req[3] pulse while code 5 is held
      add(1, 8'h20, 0,  0, 0, 8'h20, 0);
      add(1, 8'h08, 0,  1, 5, 8'h08, 0);
      add(1, 8'h08, 0,  1, 5, 8'h08, 1);
      add(1, 8'h00, 0,  1, 5, 8'h08, 0);
      add(1, 8'h00, 1,  1, 3, 8'h00, 0);
      add(1, 8'h00, 1,  0, 0, 8'h00, 0);
      // req on the line being loaded re-arms it, no ovf
      add(1, 8'h40, 0,  0, 0, 8'h40, 0);
      add(1, 8'h40, 0,  1, 6, 8'h40, 0);
      add(1, 8'h00, 1,  1, 6, 8'h00, 0);
      add(1, 8'h00, 1,  0, 0, 8'h00, 0);
      // enable gating
      add(0, 8'hFF, 1,  0, 0, 8'h00, 0);
      add(0, 8'hFF, 1,  0, 0, 8'h00, 0);
      add(1, 8'h03, 0,  0, 0, 8'h03, 0);
      add(1, 8'h00, 0,  1, 1, 8'h01, 0);
      add(0, 8'hFF, 1,  0, 0, 8'h01, 0);
      add(0, 8'h00, 0,  0, 0, 8'h01, 0);
      add(1, 8'h00, 1,  1, 0, 8'h00, 0);
      add(1, 8'h00, 1,  0, 0, 8'h00, 0);

      // reset state
      rst_n = 1'b0;
      drive(1, 8'hFF, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset valid", 32'(bus.valid), 32'd0);
      chk("reset code", 32'(bus.code), 32'd0);
      chk("reset pending", 32'(bus.pending), 32'd0);
      chk("reset ovf", 32'(bus.ovf), 32'd0);
      chk("reset state", 32'(state), 32'(IDLE));
      drive(1, 8'h00, 1);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         v = vq[i];
         step(v.en, v.req, v.ready);
         check_outputs($sformatf("vec%0d", i), v);
      end

      // reset while code 6 is held with line 3 still pending
      step(1, 8'h48, 0);
      step(1, 8'h00, 0);
      chk("mid valid", 32'(bus.valid), 32'd1);
      chk("mid code", 32'(bus.code), 32'd6);
      chk("mid pending", 32'(bus.pending), 32'h08);
      rst_n = 1'b0;
      step(1, 8'h00, 1);
      chk("rst mid valid", 32'(bus.valid), 32'd0);
      chk("rst mid code", 32'(bus.code), 32'd0);
      chk("rst mid pending", 32'(bus.pending), 32'h00);
      chk("rst mid state", 32'(state), 32'(IDLE));
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1, 8'h00, 1);
         chk($sformatf("post rst valid%0d", k), 32'(bus.valid), 32'd0);
         chk($sformatf("post rst pending%0d", k), 32'(bus.pending), 32'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
